inc_sequencer: RTL and testbench

Sequencer between the synchronized increment buttons and the per-digit counter chain. It captures rising edges on each digit's request line and grants one increment pulse at a time to a digit counter, using round-robin order. After each pulse it waits for carry propagation, then requests a display refresh from the serial 7-segment shifter and waits for that shifter to finish before granting the next increment.

---
 rtl/adv_cnt_pkg.sv | 15 +
 rtl/rr_pick.sv | 22 ++
 rtl/inc_sequencer.sv | 113 +++++++++++
 tb/tb_inc_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adv_cnt_pkg.sv
// adv_cnt_pkg: shared FSM state encoding and default timing constants for the increment sequencer
package adv_cnt_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    SETTLE  = 3'd2,
    REFRESH = 3'd3,
    DRAIN   = 3'd4
  } state_t;
  localparam int DEF_DIGITS = 4;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_REFRESH_TIMEOUT = 16;
  localparam int DEF_TICK_DIV = 1000;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first pending lane at or after ptr (wrapping)
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         pending,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);
  localparam int IW = $clog2(N);
  always_comb begin
    logic [IW-1:0] j;
    j = '0;
    idx = '0;
    valid = |pending;
    // walk backwards so the lane closest to ptr is the last (winning) assignment
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (pending[j]) idx = j;
    end
  end
endmodule

// File: rtl/inc_sequencer.sv
// inc_sequencer: round-robin increment sequencer with carry settle and display refresh handshake; ADV_CNT_AUTOTICK_EN adds an auto-tick on lane 0
module inc_sequencer
  import adv_cnt_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int REFRESH_TIMEOUT = DEF_REFRESH_TIMEOUT,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIGITS-1:0] req_in,
  input  logic              auto_en,
  input  logic              shift_busy,
  output logic [DIGITS-1:0] inc_out,
  output logic              refresh_out,
  output logic              busy_out,
  output logic [DIGITS-1:0] pending_out
);
  localparam int IW = $clog2(DIGITS);
  localparam int TW = $clog2(REFRESH_TIMEOUT + 1);
  state_t state, state_n;
  logic [DIGITS-1:0] req_d, pending, pending_n, clr, tick_set;
  logic [IW-1:0] ptr, ptr_n, idx, idx_n, pick;
  logic valid;
  logic [3:0] scnt, scnt_n;
  logic [TW-1:0] tcnt, tcnt_n;

  rr_pick #(.N(DIGITS)) u_pick (
    .pending(pending),
    .ptr(ptr),
    .idx(pick),
    .valid(valid)
  );

`ifdef ADV_CNT_AUTOTICK_EN
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] pcnt;
  logic wrap;
  assign wrap = auto_en && pcnt == PW'(TICK_DIV - 1);
  assign tick_set = {{(DIGITS-1){1'b0}}, wrap};
  always_ff @(posedge clk or posedge reset)
    if (reset) pcnt <= '0;
    else pcnt <= (!auto_en || wrap) ? '0 : pcnt + 1'b1;
`else
  logic unused;
  assign unused = auto_en | (TICK_DIV < 0);
  assign tick_set = '0;
`endif

  always_comb begin
    state_n = state;
    idx_n = idx;
    ptr_n = ptr;
    scnt_n = scnt;
    tcnt_n = tcnt;
    clr = '0;
    case (state)
      IDLE: if (valid) begin
        state_n = GRANT;
        idx_n = pick;
      end
      GRANT: begin
        state_n = SETTLE;
        scnt_n = 4'(SETTLE_CYCLES - 1);
        clr[idx] = 1'b1;
        ptr_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
      SETTLE: begin
        scnt_n = (scnt == 4'd0) ? 4'd0 : scnt - 4'd1;
        tcnt_n = '0;
        if (scnt == 4'd0) state_n = REFRESH;
      end
      REFRESH: begin
        tcnt_n = (shift_busy || tcnt == TW'(REFRESH_TIMEOUT - 1)) ? '0 : tcnt + 1'b1;
        if (shift_busy) state_n = DRAIN;
        else if (tcnt == TW'(REFRESH_TIMEOUT - 1)) state_n = IDLE;
      end
      DRAIN: if (!shift_busy) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // a fresh edge on the lane being cleared wins over the clear
    pending_n = (pending & ~clr) | (req_in & ~req_d) | tick_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      ptr <= '0;
      scnt <= '0;
      tcnt <= '0;
      req_d <= '0;
      pending <= '0;
      inc_out <= '0;
      refresh_out <= 1'b0;
      busy_out <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      ptr <= ptr_n;
      scnt <= scnt_n;
      tcnt <= tcnt_n;
      req_d <= req_in;
      pending <= pending_n;
      inc_out <= (state_n == GRANT) ? (DIGITS'(1) << idx_n) : '0;
      refresh_out <= state_n == REFRESH;
      busy_out <= state_n != IDLE;
    end
  end

  assign pending_out = pending;
endmodule

// File: tb/tb_inc_sequencer.sv
// tb_inc_sequencer: directed self-checking bench for inc_sequencer (DIGITS=4, SETTLE_CYCLES=2, REFRESH_TIMEOUT=16)
module tb_inc_sequencer;
  logic clk = 1'b0, reset = 1'b1, auto_en = 1'b0, shift_busy = 1'b0;
  logic [3:0] req_in = '0, inc_out, pending_out;
  logic refresh_out, busy_out;
  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;

  inc_sequencer dut (
    .clk(clk),
    .reset(reset),
    .req_in(req_in),
    .auto_en(auto_en),
    .shift_busy(shift_busy),
    .inc_out(inc_out),
    .refresh_out(refresh_out),
    .busy_out(busy_out),
    .pending_out(pending_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_inc(input int lim, output logic [3:0] got, output int at);
    got = '0;
    at = -1;
    for (int i = 0; i < lim && got == 4'b0; i++) begin
      tick();
      if (inc_out != 4'b0) begin
        got = inc_out;
        at = cyc;
      end
    end
  endtask

  task automatic serve(output logic ok);
    ok = refresh_out;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = refresh_out;
    end
    if (ok) begin
      shift_busy = 1'b1;
      tick();
      shift_busy = 1'b0;
    end
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (inc_out != 4'b0) p++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_in = '0;
    shift_busy = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] lanes);
    req_in = lanes;
    tick();
    req_in = '0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (inc_out !== 4'b0) begin errors++; $display("FAIL reset_inc got %b exp 0000", inc_out); end
    checks++; if (refresh_out !== 1'b0) begin errors++; $display("FAIL reset_refresh got %b exp 0", refresh_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_out); end
    checks++; if (pending_out !== 4'b0) begin errors++; $display("FAIL reset_pending got %b exp 0000", pending_out); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    press(4'b0100);
    checks++; if (pending_out !== 4'b0100) begin errors++; $display("FAIL single_pending got %b exp 0100", pending_out); end
    checks++; if (inc_out !== 4'b0) begin errors++; $display("FAIL single_inc_e0 got %b exp 0000", inc_out); end
    tick();
    checks++; if (inc_out !== 4'b0100) begin errors++; $display("FAIL single_inc_e1 got %b exp 0100", inc_out); end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL single_busy_e1 got %b exp 1", busy_out); end
    tick();
    checks++; if (inc_out !== 4'b0) begin errors++; $display("FAIL single_inc_e2 got %b exp 0000", inc_out); end
    checks++; if (pending_out !== 4'b0) begin errors++; $display("FAIL single_pend_e2 got %b exp 0000", pending_out); end
    tick();
    checks++; if (refresh_out !== 1'b0) begin errors++; $display("FAIL single_refresh_e3 got %b exp 0", refresh_out); end
    tick();
    checks++; if (refresh_out !== 1'b1) begin errors++; $display("FAIL single_refresh_e4 got %b exp 1", refresh_out); end
    shift_busy = 1'b1;
    tick();
    checks++; if (refresh_out !== 1'b0) begin errors++; $display("FAIL single_refresh_e5 got %b exp 0", refresh_out); end
    tick();
    tick();
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL single_busy_drain got %b exp 1", busy_out); end
    shift_busy = 1'b0;
    tick();
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy_out); end
  endtask

  task automatic test_wrap();
    logic [3:0] g;
    int t0, t1;
    logic ok;
    press(4'b1001);
    wait_inc(10, g, t0);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b exp 1000", g); end
    serve(ok);
    wait_inc(20, g, t1);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL wrap_second got %b exp 0001", g); end
    checks++; if (t1 - t0 !== 6) begin errors++; $display("FAIL wrap_spacing got %0d exp 6", t1 - t0); end
    serve(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_refresh got %b exp 1", ok); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g[3] = '{4'b0001, 4'b0010, 4'b1000};
    logic [3:0] g;
    int t, prev;
    logic ok;
    do_reset();
    press(4'b1011);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_inc(20, g, t);
      checks++; if (g !== exp_g[k]) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, g, exp_g[k]); end
      if (k > 0) begin
        checks++; if (t - prev !== 6) begin errors++; $display("FAIL rr_spacing%0d got %0d exp 6", k, t - prev); end
      end
      prev = t;
      serve(ok);
    end
    tick();
    tick();
    press(4'b1001);
    wait_inc(10, g, t);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL rr_ptr_end got %b exp 0001", g); end
    serve(ok);
  endtask

  task automatic test_set_wins();
    logic [3:0] g;
    int t;
    logic ok;
    do_reset();
    press(4'b0010);
    tick();
    checks++; if (inc_out !== 4'b0010) begin errors++; $display("FAIL setwins_inc got %b exp 0010", inc_out); end
    req_in = 4'b0010;
    tick();
    req_in = '0;
    checks++; if (pending_out !== 4'b0010) begin errors++; $display("FAIL setwins_pending got %b exp 0010", pending_out); end
    serve(ok);
    wait_inc(20, g, t);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL setwins_regrant got %b exp 0010", g); end
    serve(ok);
  endtask

  task automatic test_coalesce();
    logic [3:0] g;
    int t, p;
    logic ok;
    do_reset();
    press(4'b0100);
    wait_inc(10, g, t);
    for (int i = 0; i < 10 && !refresh_out; i++) tick();
    checks++; if (refresh_out !== 1'b1) begin errors++; $display("FAIL coal_refresh got %b exp 1", refresh_out); end
    for (int i = 0; i < 3; i++) press(4'b0010);
    checks++; if (pending_out !== 4'b0010) begin errors++; $display("FAIL coal_pending got %b exp 0010", pending_out); end
    shift_busy = 1'b1;
    tick();
    shift_busy = 1'b0;
    wait_inc(20, g, t);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL coal_grant got %b exp 0010", g); end
    serve(ok);
    count_pulses(30, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL coal_extra got %0d exp 0", p); end
  endtask

  task automatic test_timeout();
    logic [3:0] g;
    int t, n, p;
    do_reset();
    press(4'b0001);
    wait_inc(10, g, t);
    for (int i = 0; i < 10 && !refresh_out; i++) tick();
    n = 0;
    while (refresh_out && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL timeout_len got %0d exp 16", n); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL timeout_idle got %b exp 0", busy_out); end
    count_pulses(20, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL timeout_extra got %0d exp 0", p); end
  endtask

  task automatic test_reset_mid_grant();
    int p;
    do_reset();
    press(4'b0101);
    tick();
    checks++; if (inc_out !== 4'b0001) begin errors++; $display("FAIL rmid_inc got %b exp 0001", inc_out); end
    #2 reset = 1'b1;
    #1;
    checks++; if (inc_out !== 4'b0) begin errors++; $display("FAIL rmid_async_inc got %b exp 0000", inc_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rmid_async_busy got %b exp 0", busy_out); end
    checks++; if (pending_out !== 4'b0) begin errors++; $display("FAIL rmid_async_pend got %b exp 0000", pending_out); end
    checks++; if (refresh_out !== 1'b0) begin errors++; $display("FAIL rmid_async_refresh got %b exp 0", refresh_out); end
    tick();
    reset = 1'b0;
    count_pulses(20, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL rmid_no_reissue got %0d exp 0", p); end
    press(4'b0100);
    tick();
    checks++; if (inc_out !== 4'b0100) begin errors++; $display("FAIL rmid_new_edge got %b exp 0100", inc_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_set_wins();
    test_coalesce();
    test_timeout();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
